vend_controller: RTL
====================

Name: vend_controller

Overview:
- Credit and sequencing controller for the vending datapath.
- Accepts nickel and dime coin events and accumulates credit in nickel units.
- Arbitrates a 4-item selection against per-item prices, then drives a single dispenser mechanism through a req/done handshake with timeout.
- Returns leftover credit as a train of one-nickel change pulses.

Parameters:
- PRICE0, 3, price of item 0 in nickels (15 cents)
- PRICE1, 4, price of item 1 in nickels
- PRICE2, 5, price of item 2 in nickels
- PRICE3, 7, price of item 3 in nickels
- MAX_CREDIT, 20, credit ceiling in nickels (100 cents); must be 63 or less
- TIMEOUT, 16, cycles to wait for disp_done before declaring a fault

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin  in  2  coin event, valid for one cycle: 01 = nickel, 10 = dime, 00/11 = no coin
- sel_valid  in  1  selection strobe
- sel_item  in  2  item index, sampled when sel_valid = 1
- cancel  in  1  refund request
- disp_done  in  1  dispenser completion acknowledge
- disp_req  out  1  dispense request, level
- disp_item  out  2  item being dispensed
- change_nickel  out  1  one-cycle pulse per nickel returned
- coin_reject  out  1  one-cycle pulse: coin not credited
- price_short  out  1  one-cycle pulse: selection refused for insufficient credit
- disp_fault  out  1  one-cycle pulse: dispense timed out
- credit  out  6  current credit in nickels
- busy  out  1  high in DISPENSE and CHANGE states

Behaviour:
- All outputs are registered. On reset, every output is 0, state is IDLE and the timeout counter is 0. Reset takes effect at the next edge from any state, including mid-dispense and mid-change; no change is paid out for credit lost to reset.
- States: IDLE (credit = 0), CREDIT (credit > 0), DISPENSE, CHANGE.
- Coin handling, IDLE/CREDIT:
  - A coin adds 1 (nickel) or 2 (dime) to credit, visible the next cycle.
  - If the new credit would exceed MAX_CREDIT, credit is unchanged and coin_reject pulses.
  - IDLE moves to CREDIT on the first accepted coin.
- Coin handling, DISPENSE/CHANGE: every coin is rejected (coin_reject pulses).
- Selection, IDLE/CREDIT, when sel_valid = 1:
  - If credit >= PRICE[sel_item]: credit -= price; disp_item latches sel_item; disp_req = 1 the next cycle; state moves to DISPENSE; timeout counter clears.
  - Otherwise price_short pulses and state and credit are unchanged.
- Priority within one cycle: cancel > sel_valid > coin.
  - The losing coin is rejected.
  - A selection that loses to cancel is dropped silently.
- cancel in CREDIT moves to CHANGE. cancel in IDLE does nothing.
- DISPENSE:
  - disp_req stays high and disp_item stays stable until disp_done is sampled high.
  - disp_req drops on the cycle after disp_done; state then moves to CHANGE if credit > 0, else IDLE.
  - cancel and sel_valid are ignored.
  - disp_done outside DISPENSE is ignored.
- Timeout:
  - The counter increments each DISPENSE cycle without disp_done.
  - When it reaches TIMEOUT with no disp_done: disp_req drops, disp_fault pulses, the item price is added back to credit, and state moves to CHANGE.
  - disp_done arriving on the same cycle as the timeout is treated as success.
- CHANGE:
  - change_nickel pulses once per cycle and credit decrements by 1 per pulse.
  - When credit reaches 0 the state moves to IDLE, with no extra pulse.
  - Entry with credit = 0 goes directly to IDLE.
  - cancel, sel_valid and coins are all ignored or rejected.
- Arithmetic: credit is unsigned 6-bit and never wraps. Refund after a fault cannot exceed MAX_CREDIT, because the price was previously subtracted from a legal credit.

Test Plan:
- Reset, then nickel followed by dime, then select item 0 (price 3) -> credit shows 1, then 3; after the select, disp_req = 1 with disp_item = 0 and credit = 0. Bench asserts disp_done 2 cycles later -> disp_req drops, state returns to IDLE, no change_nickel pulses.
- Insert 4 dimes (credit 8), select item 3 (price 7), complete the dispense -> credit = 1, then exactly 1 change_nickel pulse, then credit = 0 and busy = 0.
- Credit 2, select item 2 (price 5) -> price_short pulses once and credit stays 2. Then cancel -> 2 consecutive change_nickel pulses, then IDLE.
- Credit 19, insert dime -> coin_reject pulses and credit stays 19. Insert nickel -> credit = 20. In one cycle assert cancel + sel_valid + coin -> coin_reject pulses and 20 change_nickel pulses follow.
- Credit 6, select item 1 (price 4), never assert disp_done -> after 16 cycles disp_fault pulses, disp_req drops, credit = 6, then 6 change_nickel pulses.
- Credit 10, select item 2, then assert reset on the 3rd DISPENSE cycle -> the next cycle shows all outputs 0 and state IDLE; a subsequent nickel gives credit = 1.

Source files
------------

// File: rtl/vend_controller.sv
// Vending credit/sequencing controller: accumulates nickel credit, arbitrates item
// selection, runs a timed req/done dispense handshake and pays change one nickel per cycle.
module vend_controller #(
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 7,
  parameter int MAX_CREDIT = 20,
  parameter int TIMEOUT    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       disp_done,
  output logic       disp_req,
  output logic [1:0] disp_item,
  output logic       change_nickel,
  output logic       coin_reject,
  output logic       price_short,
  output logic       disp_fault,
  output logic [5:0] credit,
  output logic       busy
);

  // Dispenser handshake: disp_req is a level held with disp_item stable until disp_done
  // is sampled high; the request drops the following cycle or on timeout.

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [5:0]    credit_nx;
  logic [1:0]    disp_item_nx;
  logic          disp_req_nx, change_nx, reject_nx, short_nx, fault_nx, busy_nx;

  function automatic logic [5:0] price_of(input logic [1:0] item);
    case (item)
      2'd0:    return 6'(PRICE0);
      2'd1:    return 6'(PRICE1);
      2'd2:    return 6'(PRICE2);
      default: return 6'(PRICE3);
    endcase
  endfunction

  logic       coin_valid, coin_fits, sel_ok, timed_out, accepting;
  logic [1:0] coin_amt;
  logic [6:0] coin_sum;
  logic [5:0] sel_price;

  assign coin_valid = ^coin;
  assign coin_amt   = (coin == 2'b01) ? 2'd1 : (coin == 2'b10) ? 2'd2 : 2'd0;
  assign coin_sum   = {1'b0, credit} + {5'd0, coin_amt};
  assign coin_fits  = coin_sum <= 7'(MAX_CREDIT);
  assign sel_price  = price_of(sel_item);
  assign sel_ok     = credit >= sel_price;
  assign timed_out  = tmo_cnt == TW'(TIMEOUT - 1);
  assign accepting  = (state == IDLE) || (state == CREDIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      credit        <= '0;
      disp_req      <= 1'b0;
      disp_item     <= '0;
      change_nickel <= 1'b0;
      coin_reject   <= 1'b0;
      price_short   <= 1'b0;
      disp_fault    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      tmo_cnt       <= tmo_nx;
      credit        <= credit_nx;
      disp_req      <= disp_req_nx;
      disp_item     <= disp_item_nx;
      change_nickel <= change_nx;
      coin_reject   <= reject_nx;
      price_short   <= short_nx;
      disp_fault    <= fault_nx;
      busy          <= busy_nx;
    end
  end

  // Priority in IDLE/CREDIT: cancel, then selection, then coin.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, CREDIT: begin
        if (cancel) begin
          if (state == CREDIT) state_nx = CHANGE;
        end else if (sel_valid) begin
          if (sel_ok) state_nx = DISPENSE;
        end else if (coin_valid && coin_fits) begin
          state_nx = CREDIT;
        end
      end
      DISPENSE: begin
        if (disp_done)      state_nx = (credit != 6'd0) ? CHANGE : IDLE;
        else if (timed_out) state_nx = CHANGE;
      end
      CHANGE: begin
        if (credit <= 6'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    credit_nx    = credit;
    disp_req_nx  = disp_req;
    disp_item_nx = disp_item;
    tmo_nx       = tmo_cnt;
    change_nx    = 1'b0;
    short_nx     = 1'b0;
    fault_nx     = 1'b0;
    reject_nx    = coin_valid && !accepting;
    if (accepting) begin
      if (cancel) begin
        reject_nx = coin_valid;
      end else if (sel_valid) begin
        reject_nx = coin_valid;
        if (sel_ok) begin
          credit_nx    = credit - sel_price;
          disp_req_nx  = 1'b1;
          disp_item_nx = sel_item;
          tmo_nx       = '0;
        end else begin
          short_nx = 1'b1;
        end
      end else if (coin_valid) begin
        if (coin_fits) credit_nx = coin_sum[5:0];
        else           reject_nx = 1'b1;
      end
    end else if (state == DISPENSE) begin
      // A done coinciding with the timeout wins: the item was delivered.
      if (disp_done) begin
        disp_req_nx = 1'b0;
      end else if (timed_out) begin
        disp_req_nx = 1'b0;
        fault_nx    = 1'b1;
        credit_nx   = credit + price_of(disp_item);
      end else begin
        tmo_nx = tmo_cnt + 1'b1;
      end
    end else if (credit != 6'd0) begin
      change_nx = 1'b1;
      credit_nx = credit - 6'd1;
    end
    busy_nx = (state_nx == DISPENSE) || (state_nx == CHANGE);
  end

endmodule
